// File: rtl/tri_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tri_bus_pkg
//  Description : Shared types, default constants and helpers for the
//                tri-state bus arbiter and its round-robin picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package tri_bus_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // Default configuration
    localparam int c_def_n_req    = 4;
    localparam int c_def_max_hold = 8;
    localparam int c_def_turn_cyc = 1;

    // Widest requester vector any instance may use
    localparam int c_max_req = 16;

    // One-hot encode an index into a c_max_req-wide vector; callers
    // truncate to their own requester count.
    function automatic logic [c_max_req-1:0] onehot(input int idx);
        logic [c_max_req-1:0] oh;
        for (int i = 0; i < c_max_req; i++) begin
            oh[i] = (idx == i);
        end
        return oh;
    endfunction

endpackage : tri_bus_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority scan. Starting at i_ptr
//                and wrapping modulo N_REQ, the first set request wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int N_REQ = c_def_n_req,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any_req
);

    logic [IDX_W-1:0] w_idx;

    // Walk the requesters in priority order beginning at the pointer
    always_comb begin
        o_winner  = '0;
        o_any_req = 1'b0;
        w_idx     = i_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_any_req && i_req[w_idx]) begin
                o_any_req = 1'b1;
                o_winner  = w_idx;
            end
            w_idx = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/tri_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tri_bus_arbiter
//  Description : Round-robin owner selection for a shared tri-state bus.
//                Produces registered one-hot driver enables, caps each
//                ownership at MAX_HOLD cycles and floats the bus for
//                TURN_CYC cycles between owners.
//  Revision    : 1.0 - initial release
// ============================================================================
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N_REQ    = c_def_n_req,
    parameter int MAX_HOLD = c_def_max_hold,
    parameter int TURN_CYC = c_def_turn_cyc,
    parameter int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] drv_en,
    output logic [IDX_W-1:0] grant_id,
    output logic             bus_busy,
    output logic             turn
);

    localparam int c_hold_w = $clog2(MAX_HOLD + 1);
    localparam int c_turn_w = $clog2(TURN_CYC + 1);
    localparam logic [c_hold_w-1:0] c_max_hold = c_hold_w'(MAX_HOLD);
    localparam logic [c_turn_w-1:0] c_turn_cyc = c_turn_w'(TURN_CYC);

    // Registered state and outputs
    state_t              r_state_q;
    logic [IDX_W-1:0]    r_ptr_q;
    logic [c_hold_w-1:0] r_hold_q;
    logic [c_turn_w-1:0] r_turn_cnt_q;
    logic [N_REQ-1:0]    r_drv_en_q;
    logic [IDX_W-1:0]    r_grant_id_q;
    logic                r_bus_busy_q;
    logic                r_turn_q;

    // Next-state values
    state_t              w_state_d;
    logic [IDX_W-1:0]    w_ptr_d;
    logic [c_hold_w-1:0] w_hold_d;
    logic [c_turn_w-1:0] w_turn_cnt_d;
    logic [N_REQ-1:0]    w_drv_en_d;
    logic [IDX_W-1:0]    w_grant_id_d;
    logic                w_bus_busy_d;
    logic                w_turn_d;

    // Arbitration result
    logic [IDX_W-1:0]    w_winner;
    logic                w_any_req;
    logic [N_REQ-1:0]    w_winner_oh;
    logic                w_owner_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req     (req),
        .i_ptr     (r_ptr_q),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    assign w_winner_oh = N_REQ'(onehot(int'(w_winner)));
    assign w_owner_req = req[r_grant_id_q];

    // Next-state logic: grant, hold/release, turnaround sequencing
    always_comb begin
        w_state_d    = r_state_q;
        w_ptr_d      = r_ptr_q;
        w_hold_d     = r_hold_q;
        w_turn_cnt_d = r_turn_cnt_q;
        w_drv_en_d   = r_drv_en_q;
        w_grant_id_d = r_grant_id_q;
        w_bus_busy_d = r_bus_busy_q;
        w_turn_d     = r_turn_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_d    = ST_GRANT;
                    w_drv_en_d   = w_winner_oh;
                    w_grant_id_d = w_winner;
                    w_bus_busy_d = 1'b1;
                    w_hold_d     = c_hold_w'(1);
                end
            end

            ST_GRANT: begin
                if (w_owner_req && (r_hold_q < c_max_hold)) begin
                    w_hold_d = r_hold_q + c_hold_w'(1);
                end else begin
                    // Release: float the bus and move priority past the owner
                    w_state_d    = ST_TURN;
                    w_drv_en_d   = '0;
                    w_bus_busy_d = 1'b0;
                    w_turn_d     = 1'b1;
                    w_turn_cnt_d = c_turn_cyc;
                    w_ptr_d      = (r_grant_id_q == IDX_W'(N_REQ - 1)) ?
                                   '0 : r_grant_id_q + IDX_W'(1);
                end
            end

            ST_TURN: begin
                if (r_turn_cnt_q <= c_turn_w'(1)) begin
                    // Last turnaround cycle: hand straight to the next owner
                    w_turn_d     = 1'b0;
                    w_turn_cnt_d = '0;
                    if (w_any_req) begin
                        w_state_d    = ST_GRANT;
                        w_drv_en_d   = w_winner_oh;
                        w_grant_id_d = w_winner;
                        w_bus_busy_d = 1'b1;
                        w_hold_d     = c_hold_w'(1);
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end else begin
                    w_turn_cnt_d = r_turn_cnt_q - c_turn_w'(1);
                end
            end

            default: begin
                w_state_d    = ST_IDLE;
                w_drv_en_d   = '0;
                w_bus_busy_d = 1'b0;
                w_turn_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset floats the bus immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_ptr_q      <= '0;
            r_hold_q     <= '0;
            r_turn_cnt_q <= '0;
            r_drv_en_q   <= '0;
            r_grant_id_q <= '0;
            r_bus_busy_q <= 1'b0;
            r_turn_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_ptr_q      <= w_ptr_d;
            r_hold_q     <= w_hold_d;
            r_turn_cnt_q <= w_turn_cnt_d;
            r_drv_en_q   <= w_drv_en_d;
            r_grant_id_q <= w_grant_id_d;
            r_bus_busy_q <= w_bus_busy_d;
            r_turn_q     <= w_turn_d;
        end
    end

    assign drv_en   = r_drv_en_q;
    assign grant_id = r_grant_id_q;
    assign bus_busy = r_bus_busy_q;
    assign turn     = r_turn_q;

endmodule : tri_bus_arbiter
`default_nettype wire

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Round-robin arbiter for a shared single-wire tri-state bus.
- Drives the one-hot enables of N tri_buff drivers that are wired onto that bus. It is the stage directly upstream of those drivers.
- Guarantees that at most one driver is enabled at a time.
- Inserts turnaround cycles, during which the bus floats at Z, between owners so drivers never contend.
- Limits each ownership period to a maximum hold time so no requester can starve the others.

Parameters:
- N_REQ, 4, number of requesters/drivers; legal range 2..16.
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps its enable high; minimum 1.
- TURN_CYC, 1, cycles with all enables low between two ownership periods; minimum 1.
- IDX_W, $clog2(N_REQ), width of the grant index (derived; not overridden).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester bus request; level-sensitive; held high while the requester wants the bus.
- drv_en  output  N_REQ  registered one-hot-or-zero enables; bit i connects to the enable of driver i's tri_buff.
- grant_id  output  IDX_W  index of the current owner; valid only while bus_busy=1.
- bus_busy  output  1  high while any drv_en bit is high.
- turn  output  1  high during turnaround cycles.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - drv_en=0, grant_id=0, bus_busy=0, turn=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- All outputs are registered. No combinational path from req to drv_en.
- States: IDLE, GRANT, TURN.
- Arbitration function: scan req starting at ptr, wrapping modulo N_REQ; the first set bit wins.
- IDLE:
  - If req is nonzero at a rising edge: go to GRANT.
  - Same edge: drv_en=onehot(winner), grant_id=winner, bus_busy=1, hold=1.
  - Grant latency is exactly 1 cycle from req being sampled.
- GRANT:
  - Each edge, if req[grant_id]=1 and hold<MAX_HOLD: stay in GRANT, hold++.
  - Release condition: req[grant_id]=0, or hold==MAX_HOLD.
  - On release, at that edge:
    - drv_en=0, bus_busy=0, turn=1, go to TURN.
    - ptr=(grant_id+1) mod N_REQ.
    - Turnaround counter loaded with TURN_CYC.
  - Result: the owner's enable stays high for at most MAX_HOLD cycles.
- TURN:
  - turn=1 and drv_en=0 for exactly TURN_CYC cycles.
  - On the edge ending the last turnaround cycle:
    - If req is nonzero: arbitrate from ptr, go directly to GRANT (enable high on the next cycle), turn=0.
    - Otherwise: go to IDLE, turn=0.
- Requests from other requesters during GRANT are ignored until arbitration. They cannot preempt the current owner.
- A forced release at MAX_HOLD with the owner still requesting: the owner re-enters the arbitration pool. Because ptr has advanced, other pending requesters win first. If the owner is the only requester, it is re-granted after turnaround.
- Wrap-around: with ptr=N_REQ-1, the scan order is N_REQ-1, 0, 1, …
- Invariants, checked by assertion in the bench:
  - $onehot0(drv_en) always.
  - drv_en never changes from one nonzero value to a different nonzero value without at least TURN_CYC zero cycles between them.
  - bus_busy==|drv_en.
  - turn and bus_busy are never both high.
- Reset asserted mid-grant: drv_en drops to 0 asynchronously and the bus floats. After release, arbitration restarts from ptr=0.
- X on req: the treatment is undefined. The bench drives only 0/1.

Decomposition:
- Shared package tri_bus_pkg:
  - State enum (IDLE, GRANT, TURN).
  - Default parameter constants.
  - A function for one-hot encoding of an index.
- One natural sub-module: rr_pick.
  - Combinational masked priority scan.
  - Inputs: req, ptr. Outputs: winner index, any_req.
  - Reusable by other arbiters.
- The state, hold and turnaround counters stay in tri_bus_arbiter.

Test Plan:
All scenarios use the defaults N_REQ=4, MAX_HOLD=8, TURN_CYC=1.
1. Reset and single request: reset, then req=0001 held for 3 cycles then dropped → drv_en=0001 starting 1 cycle after req, high for 3 cycles, then 1 cycle turn=1, drv_en=0000, state IDLE.
2. All requesting continuously: req=1111 → grant order 0,1,2,3,0; each owner holds 8 cycles; exactly 1 turn cycle between owners; drv_en never has two bits high.
3. Lone hog: req=0100 held for 20 cycles → drv_en=0100 for 8 cycles, 1 turn cycle, 8 cycles, 1 turn cycle, then the remainder; grant_id=2 throughout each grant.
4. Pointer wrap: ptr=3 after a grant to 2; req=1001 → requester 3 is granted first, then 0.
5. Reset mid-grant: with drv_en=0010, assert rst between clock edges → drv_en=0000 immediately without waiting for an edge; after release, req=1010 grants requester 1 first (ptr=0).
6. Late competitor: requester 0 owns the bus; requester 3 raises req mid-grant → no preemption; 3 is granted after 0 drops its request plus 1 turn cycle.
